// File: rtl/mua_stream_arbiter_pkg.sv
// mua_stream_arbiter_pkg: shared widths, FSM states and the detector word layout
package mua_stream_arbiter_pkg;
  localparam int T_W = 32;
  localparam int CH_W = 12;
  localparam int HASH_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [T_W-1:0] frame_no;
    logic [CH_W-1:0] ch_ref;
    logic [CH_W-1:0] ch_no;
    logic [HASH_W-1:0] ch_hash;
    logic [DATA_W-1:0] thr;
    logic [DATA_W-1:0] mua;
  } mua_word_t;
endpackage

// File: rtl/mua_stream_arbiter_rr_pick.sv
// rr_pick: first set request found circularly starting at ptr
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       idx,
  output logic             any
);
  // Descending offset so the nearest requester after ptr wins
  always_comb begin
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      for (int j = 0; j < N_REQ; j++)
        if (req[j] && ((int'(ptr) + k) % N_REQ) == j) idx = 3'(j);
  end
  assign any = |req;
endmodule

// File: rtl/mua_stream_arbiter.sv
// mua_stream_arbiter: round-robin burst arbiter feeding the spike detector stream
module mua_stream_arbiter
  import mua_stream_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_BURST = 32,
  parameter int IDLE_TMO = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [T_W*N_REQ-1:0]    req_frameNo,
  input  logic [CH_W*N_REQ-1:0]   req_ch_ref,
  input  logic [CH_W*N_REQ-1:0]   req_chNo,
  input  logic [HASH_W*N_REQ-1:0] req_ch_hash,
  input  logic [DATA_W*N_REQ-1:0] req_thr,
  input  logic [DATA_W*N_REQ-1:0] req_mua,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    dn_afull,
  output logic                    mua_valid,
  output logic [T_W-1:0]          frameNo_out,
  output logic [CH_W-1:0]         ch_ref_out,
  output logic [CH_W-1:0]         chNo_out,
  output logic [HASH_W-1:0]       ch_hash_out,
  output logic [DATA_W-1:0]       thr_data_out,
  output logic [DATA_W-1:0]       mua_data_out,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [15:0]             tmo_cnt
);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int TM_W = $clog2(IDLE_TMO + 1);
  state_t state, state_n;
  logic [2:0] g, g_n, rr_ptr, rr_n, pick;
  logic [BC_W-1:0] burst_cnt, bc_n;
  logic [TM_W-1:0] tmo, tmo_n;
  logic [15:0] tc_n;
  logic any, v_g, l_g, xfer, done;
  mua_word_t word_g, word_q;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .idx(pick),
    .any(any)
  );
  always_comb begin
    word_g = '0;
    v_g = 1'b0;
    l_g = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (g == 3'(i)) begin
        v_g = req_valid[i];
        l_g = req_last[i];
        word_g = {req_frameNo[i*T_W +: T_W], req_ch_ref[i*CH_W +: CH_W], req_chNo[i*CH_W +: CH_W],
                  req_ch_hash[i*HASH_W +: HASH_W], req_thr[i*DATA_W +: DATA_W], req_mua[i*DATA_W +: DATA_W]};
      end
  end
  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_ready[i] = state == HOLD && g == 3'(i) && !dn_afull;
  end
  always_comb begin
    state_n = state;
    g_n = g;
    bc_n = burst_cnt;
    tmo_n = tmo;
    rr_n = rr_ptr;
    tc_n = tmo_cnt;
    xfer = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      if (any && !dn_afull) begin
        state_n = HOLD;
        g_n = pick;
        bc_n = '0;
        tmo_n = '0;
      end
    end else begin
      xfer = v_g && !dn_afull;
      bc_n = xfer ? burst_cnt + 1'b1 : burst_cnt;
      tmo_n = v_g ? '0 : tmo + 1'b1;
      // A last word landing on the burst limit still yields one release
      done = xfer && (l_g || bc_n == BC_W'(MAX_BURST));
      if (!v_g && tmo_n == TM_W'(IDLE_TMO)) begin
        done = 1'b1;
        tc_n = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
      end
      if (done) begin
        state_n = IDLE;
        rr_n = (g == 3'(N_REQ - 1)) ? 3'd0 : g + 3'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      burst_cnt <= '0;
      tmo <= '0;
      rr_ptr <= '0;
      tmo_cnt <= '0;
      mua_valid <= 1'b0;
      word_q <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      burst_cnt <= bc_n;
      tmo <= tmo_n;
      rr_ptr <= rr_n;
      tmo_cnt <= tc_n;
      mua_valid <= xfer;
      if (xfer) word_q <= word_g;
    end
  end
  assign frameNo_out = word_q.frame_no;
  assign ch_ref_out = word_q.ch_ref;
  assign chNo_out = word_q.ch_no;
  assign ch_hash_out = word_q.ch_hash;
  assign thr_data_out = word_q.thr;
  assign mua_data_out = word_q.mua;
  assign grant_id = g;
  assign busy = state == HOLD;
endmodule
